// File: rtl/cache_mem_arbiter_if.sv
// Cache/memory line-port bundle shared by icache, dcache and physical memory.
// The arbiter takes the slave view; the caches plus memory take the master view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write,
        input  d_address, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write,
        output d_address, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port
// between the icache miss path and the dcache miss/write-back path.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input logic                 clk,
    input logic                 reset_n,
    cache_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    logic                  last_d;
    logic                  rd_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  d_req;
    logic                  gnt_i;
    logic                  gnt_d;

    // On contention the side that did not win last time gets the port.
    assign d_req = bus.d_read | bus.d_write;
    assign gnt_i = bus.i_read & (~d_req | last_d);
    assign gnt_d = d_req & (~bus.i_read | ~last_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_i) begin
                        state   <= SERVE_I;
                        last_d  <= 1'b0;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= bus.i_address;
                        wdata_q <= bus.d_wdata;
                    end else if (gnt_d) begin
                        // read+write together is treated as a write-back
                        state   <= SERVE_D;
                        last_d  <= 1'b1;
                        rd_q    <= ~bus.d_write;
                        wr_q    <= bus.d_write;
                        addr_q  <= bus.d_address;
                        wdata_q <= bus.d_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_resp  = bus.pmem_resp & (state == SERVE_I);
    assign bus.d_resp  = bus.pmem_resp & (state == SERVE_D);
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
endmodule
